read_clear_event_bank: RTL

//  Multi-channel sticky event/status register bank for the peripheral bus. I/O logic raises per-bit
//  set pulses, which are OR-accumulated into sticky status bits. A processor read returns a

---
 rtl/read_clear_event_bank.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/read_clear_event_bank.sv
// Sticky event/status register bank with clear-on-read, per-channel interrupt
// enables, saturating per-channel event counters and one registered level interrupt.
// Optional feature macro: OVERFLOW_DETECT_EN adds a sticky per-bit overflow
// register (reg 3) that also feeds the interrupt. When the macro is not
// defined, reg 3 reads as zero.
module read_clear_event_bank #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_CH      = 4,
    parameter logic [DATA_WIDTH-1:0] CLEAR_MASK  = '1,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    CNT_WIDTH   = 8
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Sys_RdEn,
    input  logic                         Sys_WrEn,
    input  logic [$clog2(NUM_CH)+2-1:0]  Sys_Addr,
    input  logic [DATA_WIDTH-1:0]        Sys_WrData,
    output logic [DATA_WIDTH-1:0]        Sys_RdData,
    output logic                         Sys_RdValid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] IO_Set,
    output logic                         Irq
);

    localparam int ADDR_W = $clog2(NUM_CH) + 2;
    localparam int CH_W   = (ADDR_W > 2) ? ADDR_W - 2 : 1;
    localparam logic [CH_W:0]          NUM_CH_L = NUM_CH[CH_W:0];
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX  = '1;

    logic [1:0]            reg_sel;
    logic [CH_W-1:0]       ch_idx;
    logic                  ch_valid;
    logic [NUM_CH-1:0]     hit;

    logic [DATA_WIDTH-1:0] status      [NUM_CH];
    logic [DATA_WIDTH-1:0] status_next [NUM_CH];
    logic [DATA_WIDTH-1:0] irq_en      [NUM_CH];
    logic [DATA_WIDTH-1:0] irq_en_next [NUM_CH];
    logic [CNT_WIDTH-1:0]  count       [NUM_CH];
    logic [CNT_WIDTH-1:0]  count_next  [NUM_CH];
`ifdef OVERFLOW_DETECT_EN
    logic [DATA_WIDTH-1:0] ovf         [NUM_CH];
    logic [DATA_WIDTH-1:0] ovf_next    [NUM_CH];
    logic [DATA_WIDTH-1:0] ovf_set;
`endif

    logic [DATA_WIDTH-1:0] set_c;
    logic [DATA_WIDTH-1:0] clr_vec;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  irq_next;

    // With a single channel there is no channel field; the index is fixed at zero.
    if (ADDR_W > 2) begin : g_ch_field
        assign ch_idx = Sys_Addr[ADDR_W-1:2];
    end else begin : g_no_ch_field
        assign ch_idx = '0;
    end

    // Decode the register selector and which (existing) channel is addressed.
    always_comb begin
        reg_sel  = Sys_Addr[1:0];
        ch_valid = ({1'b0, ch_idx} < NUM_CH_L);
        hit      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hit[c] = ch_valid && (ch_idx == CH_W'(c));
        end
    end

    // Next-state for every channel's status, enable, counter and overflow, plus the interrupt level.
    always_comb begin
        set_c    = '0;
        clr_vec  = '0;
        irq_next = 1'b0;
`ifdef OVERFLOW_DETECT_EN
        ovf_set  = '0;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            set_c   = IO_Set[c*DATA_WIDTH +: DATA_WIDTH];
            clr_vec = (hit[c] && Sys_RdEn && reg_sel == 2'd0) ? CLEAR_MASK : '0;

            status_next[c] = (status[c] & ~clr_vec) | set_c;
            irq_en_next[c] = (hit[c] && Sys_WrEn && reg_sel == 2'd1) ? Sys_WrData : irq_en[c];

            if (hit[c] && Sys_RdEn && reg_sel == 2'd2) begin
                count_next[c] = (|set_c) ? CNT_WIDTH'(1) : '0;
            end else if ((|set_c) && (count[c] != CNT_MAX)) begin
                count_next[c] = count[c] + 1'b1;
            end else begin
                count_next[c] = count[c];
            end

            irq_next = irq_next | (|(status[c] & irq_en[c]));
`ifdef OVERFLOW_DETECT_EN
            ovf_set = set_c & status[c] & ~clr_vec;
            if (hit[c] && Sys_RdEn && reg_sel == 2'd3) begin
                ovf_next[c] = ovf_set;
            end else begin
                ovf_next[c] = ovf[c] | ovf_set;
            end
            irq_next = irq_next | ((|irq_en[c]) && (|ovf[c]));
`endif
        end
    end

    // Read mux returns pre-update register contents; unknown channels read as zero.
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (hit[c]) begin
                case (reg_sel)
                    2'd0:    rd_mux = status[c];
                    2'd1:    rd_mux = irq_en[c];
                    2'd2:    rd_mux = DATA_WIDTH'(count[c]);
`ifdef OVERFLOW_DETECT_EN
                    default: rd_mux = ovf[c];
`else
                    default: rd_mux = '0;
`endif
                endcase
            end
        end
    end

    // Per-channel register storage.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                status[c] <= RESET_VALUE;
                irq_en[c] <= '0;
                count[c]  <= '0;
`ifdef OVERFLOW_DETECT_EN
                ovf[c]    <= '0;
`endif
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                status[c] <= status_next[c];
                irq_en[c] <= irq_en_next[c];
                count[c]  <= count_next[c];
`ifdef OVERFLOW_DETECT_EN
                ovf[c]    <= ovf_next[c];
`endif
            end
        end
    end

    // One-stage read pipeline and registered interrupt output.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Sys_RdData  <= '0;
            Sys_RdValid <= 1'b0;
            Irq         <= 1'b0;
        end else begin
            Sys_RdValid <= Sys_RdEn;
            if (Sys_RdEn) begin
                Sys_RdData <= rd_mux;
            end
            Irq <= irq_next;
        end
    end

endmodule
